// File: rtl/divider_n_seq.sv
// Sequential restoring divider: one quotient bit per clock through a subtractor_n stage.
// Optional sticky_o output (remainder != 0) is enabled by defining DIVIDER_STICKY_EN.

module subtractor_n #(
    parameter int width = 25
) (
    input  logic [width-1:0] a_i,
    input  logic [width-1:0] b_i,
    output logic [width-1:0] diff_o,
    output logic             borrow_o
);
    assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};
endmodule

// state | meaning
// IDLE  | waiting for start_i; accepts operands
// RUN   | one restoring iteration per cycle, nb_bit cycles
// DONE  | one-cycle done_o pulse with results valid
module divider_n_seq #(
    parameter int nb_bit = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [nb_bit-1:0] dividend_i,
    input  logic [nb_bit-1:0] divisor_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [nb_bit-1:0] quotient_o,
    output logic [nb_bit-1:0] remainder_o,
`ifdef DIVIDER_STICKY_EN
    output logic              sticky_o,
`endif
    output logic              div_zero_o
);
    localparam int cw = (nb_bit > 1) ? $clog2(nb_bit) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_next;
    logic [nb_bit:0]   rem, rem_next, shifted, diff;
    logic [nb_bit-1:0] quot, quot_next, div;
    logic [cw-1:0]     count;
    logic              borrow, last, accept, zero_div;
    logic              unused_rem_msb;

    assign shifted  = {rem[nb_bit-1:0], quot[nb_bit-1]};
    assign last     = (count == cw'(nb_bit - 1));
    assign accept   = (state == IDLE) && start_i;
    assign zero_div = (divisor_i == '0);
    assign busy_o   = (state == RUN);
    assign done_o   = (state == DONE);

    // The restored remainder is always below the divisor, so its top bit stays clear.
    assign unused_rem_msb = rem[nb_bit];

    subtractor_n #(.width(nb_bit + 1)) u_sub (
        .a_i      (shifted),
        .b_i      ({1'b0, div}),
        .diff_o   (diff),
        .borrow_o (borrow)
    );

    always_comb begin
        rem_next  = borrow ? shifted : diff;
        quot_next = {quot[nb_bit-2:0], ~borrow};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i) state_next = zero_div ? DONE : RUN;
            RUN:     if (last)    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem         <= '0;
            quot        <= '0;
            div         <= '0;
            count       <= '0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_zero_o  <= 1'b0;
`ifdef DIVIDER_STICKY_EN
            sticky_o    <= 1'b0;
`endif
        end else if (accept) begin
            if (zero_div) begin
                quotient_o  <= '1;
                remainder_o <= dividend_i;
                div_zero_o  <= 1'b1;
`ifdef DIVIDER_STICKY_EN
                sticky_o    <= |dividend_i;
`endif
            end else begin
                rem   <= '0;
                quot  <= dividend_i;
                div   <= divisor_i;
                count <= '0;
            end
        end else if (state == RUN) begin
            rem   <= rem_next;
            quot  <= quot_next;
            count <= count + cw'(1);
            if (last) begin
                quotient_o  <= quot_next;
                remainder_o <= rem_next[nb_bit-1:0];
                div_zero_o  <= 1'b0;
`ifdef DIVIDER_STICKY_EN
                sticky_o    <= |rem_next[nb_bit-1:0];
`endif
            end
        end
    end
endmodule
